// File: rtl/dac_spi_writer_if.sv
// Sample handshake between the servo output stage and the DAC SPI writer.
interface dac_spi_writer_if;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        frame_done_out;

  modport master (output data_in, output valid_in, input ready_out, input frame_done_out);
  modport slave  (input data_in, input valid_in, output ready_out, output frame_done_out);
endinterface

// File: rtl/dac_spi_writer.sv
// Serialises one signed sample per frame as {CMD, data} over SPI (CPOL=0, CPHA=0),
// then strobes LDAC_n. Optional macro OFFSET_BINARY_EN converts samples to offset binary.
module dac_spi_writer #(
  parameter logic [7:0] CMD     = 8'h01,
  parameter int         CLK_DIV = 2,
  parameter int         CS_GAP  = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  dac_spi_writer_if.slave  s_if,
  output logic             sclk_out,
  output logic             cs_n_out,
  output logic             sdi_out,
  output logic             ldac_n_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam int             CW    = 16;
  localparam logic [CW-1:0]  DIV_L = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_L = CW'(CS_GAP - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bcnt;
  logic [23:0]   sreg;
  logic [15:0]   dat_conv;
  logic [23:0]   frame;
  logic          ready_q;
  logic          done_q;

  // Sample format conversion, applied at latch time only
  always_comb begin
`ifdef OFFSET_BINARY_EN
    dat_conv = {~s_if.data_in[15], s_if.data_in[14:0]};
`else
    dat_conv = s_if.data_in;
`endif
    frame = {CMD, dat_conv};
  end

  assign s_if.ready_out      = ready_q;
  assign s_if.frame_done_out = done_q;

  // Frame FSM; every SPI pin is a register so state changes cannot glitch them
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      sreg       <= '0;
      sclk_out   <= 1'b0;
      cs_n_out   <= 1'b1;
      sdi_out    <= 1'b0;
      ldac_n_out <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s_if.valid_in && ready_q) begin
            sreg     <= frame;
            sdi_out  <= frame[23];
            cs_n_out <= 1'b0;
            ready_q  <= 1'b0;
            cnt      <= '0;
            bcnt     <= 5'd23;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == DIV_L) begin
            cnt <= '0;
            if (!sclk_out) begin
              sclk_out <= 1'b1;
            end else begin
              sclk_out <= 1'b0;
              if (bcnt == 5'd0) begin
                state <= HOLD;
              end else begin
                bcnt    <= bcnt - 5'd1;
                sreg    <= {sreg[22:0], 1'b0};
                sdi_out <= sreg[22];
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == DIV_L) begin
            cnt        <= '0;
            cs_n_out   <= 1'b1;
            sdi_out    <= 1'b0;
            ldac_n_out <= 1'b0;
            state      <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // LDAC low for the first CLK_DIV cycles; CS_GAP >= CLK_DIV so it ends in GAP
          if (cnt == DIV_L) ldac_n_out <= 1'b1;
          if (cnt == GAP_L) begin
            cnt     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
